// File: rtl/shift_arb.sv
//==============================================================================
// Module   : shift_arb
// Purpose  : Two-port (A = CPU execute, B = SPU) arbiter in front of a single
//            16-bit barrel shifter, with a one-entry response buffer per port.
//            Requests and responses both use valid/ready handshakes.
// Config   : SHIFT_ARB_FIXED_PRI_EN - when defined, port A always wins
//            contention; otherwise contention is resolved round-robin.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_arb (
    input  logic        clk,
    input  logic        rst_n,
    // Port A
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [15:0] a_in,
    input  logic [3:0]  a_cnt,
    input  logic [1:0]  a_op,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    output logic [15:0] a_rsp_data,
    // Port B
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [15:0] b_in,
    input  logic [3:0]  b_cnt,
    input  logic [1:0]  b_op,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [15:0] b_rsp_data,
    // Observation
    output logic        last_grant
);

    localparam logic [1:0] c_OP_ROL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_ROR = 2'b10;
    localparam logic [1:0] c_OP_SRL = 2'b11;

    // The shared barrel shifter: rotates are built from two opposing shifts,
    // where a shift by 16 (count 0 on the wrap side) contributes nothing.
    function automatic logic [15:0] shift16(input logic [15:0] v,
                                            input logic [3:0]  cnt,
                                            input logic [1:0]  op);
        logic [4:0]  inv;
        logic [15:0] res;
        inv = 5'd16 - {1'b0, cnt};
        res = v;
        case (op)
            c_OP_ROL: res = (v << cnt) | (v >> inv);
            c_OP_SLL: res = v << cnt;
            c_OP_ROR: res = (v >> cnt) | (v << inv);
            c_OP_SRL: res = v >> cnt;
            default:  res = v;
        endcase
        return res;
    endfunction

    logic        r_a_rsp_valid;
    logic [15:0] r_a_rsp_data;
    logic        r_b_rsp_valid;
    logic [15:0] r_b_rsp_data;
    logic        r_last_grant;

    logic        w_a_free;
    logic        w_b_free;
    logic        w_a_elig;
    logic        w_b_elig;
    logic        w_a_wins;
    logic        w_grant_a;
    logic        w_grant_b;
    logic [15:0] w_sh_in;
    logic [3:0]  w_sh_cnt;
    logic [1:0]  w_sh_op;
    logic [15:0] w_sh_out;

    // A full buffer still counts as free when it is being drained this cycle.
    assign w_a_free = !r_a_rsp_valid || a_rsp_ready;
    assign w_b_free = !r_b_rsp_valid || b_rsp_ready;
    assign w_a_elig = a_req_valid && w_a_free;
    assign w_b_elig = b_req_valid && w_b_free;

`ifdef SHIFT_ARB_FIXED_PRI_EN
    // Port A takes every contended cycle; last_grant is only observed.
    assign w_a_wins = 1'b1;
`else
    // Round-robin: A wins contention when B was granted most recently.
    assign w_a_wins = r_last_grant;
`endif

    // No grants while reset is held, so nothing handshakes into a clearing buffer.
    assign w_grant_a = rst_n && w_a_elig && (!w_b_elig || w_a_wins);
    assign w_grant_b = rst_n && w_b_elig && !w_grant_a;

    assign a_req_ready = w_grant_a;
    assign b_req_ready = w_grant_b;

    // Port A fields drive the shifter by default; output is unused without a grant.
    assign w_sh_in  = w_grant_b ? b_in  : a_in;
    assign w_sh_cnt = w_grant_b ? b_cnt : a_cnt;
    assign w_sh_op  = w_grant_b ? b_op  : a_op;
    assign w_sh_out = shift16(w_sh_in, w_sh_cnt, w_sh_op);

    // Port A response buffer: refill on grant, otherwise clear on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_data  <= 16'h0000;
        end else if (w_grant_a) begin
            r_a_rsp_valid <= 1'b1;
            r_a_rsp_data  <= w_sh_out;
        end else if (a_rsp_ready) begin
            r_a_rsp_valid <= 1'b0;
        end
    end

    // Port B response buffer: refill on grant, otherwise clear on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_data  <= 16'h0000;
        end else if (w_grant_b) begin
            r_b_rsp_valid <= 1'b1;
            r_b_rsp_data  <= w_sh_out;
        end else if (b_rsp_ready) begin
            r_b_rsp_valid <= 1'b0;
        end
    end

    // Remember the most recent grant; resets to B so A wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_a) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_b) begin
            r_last_grant <= 1'b1;
        end
    end

    assign a_rsp_valid = r_a_rsp_valid;
    assign a_rsp_data  = r_a_rsp_data;
    assign b_rsp_valid = r_b_rsp_valid;
    assign b_rsp_data  = r_b_rsp_data;
    assign last_grant  = r_last_grant;

endmodule

`default_nettype wire

// File: doc/shift_arb.md
# shift_arb

Two-port arbiter and result buffer in front of the shared 16-bit barrel shifter (`shifter`: `In`, `Cnt`, `Op`, `Out`).
- Port A serves the CPU execute stage; port B serves the SPU coprocessor.
- Each port issues shift requests over a valid/ready handshake. The block grants one request per cycle to the single shifter instance it contains, then registers the result into a one-entry response buffer owned by that port.
- Responses return over a valid/ready handshake, so one port stalling on its response does not block the other.

## Interface
Parameters:
- None. Data width is fixed at 16, count at 4, op at 2 (matches `shifter`).

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_req_valid`  in  1  port A request present
- `a_req_ready`  out  1  port A request accepted this cycle when high with `a_req_valid`
- `a_in`  in  16  port A operand
- `a_cnt`  in  4  port A shift amount
- `a_op`  in  2  port A op: 00 rol, 01 sll, 10 ror, 11 srl
- `a_rsp_valid`  out  1  port A result held
- `a_rsp_ready`  in  1  port A consumes result
- `a_rsp_data`  out  16  port A result
- `b_req_valid`, `b_req_ready`, `b_in`, `b_cnt`, `b_op`, `b_rsp_valid`, `b_rsp_ready`, `b_rsp_data`: same as the port A signals, for port B
- `last_grant`  out  1  0 = A granted most recently, 1 = B; observation only

## Operation
- Request eligibility, evaluated combinationally each cycle:
  - A port is eligible when `x_req_valid` is 1 and its response buffer is free.
  - A response buffer is free when it is empty, or when it is full and `x_rsp_ready` is 1 this cycle (drain-and-refill in the same cycle).
- Arbitration, at most one grant per cycle:
  - Only one port eligible: that port is granted.
  - Both ports eligible: round-robin. The port not named by `last_grant` wins.
  - `last_grant` updates only on a grant.
- `x_req_ready` equals the grant for that port. It is never high for a non-eligible port. It may depend combinationally on `x_req_valid` and `x_rsp_ready`.
- Shifter sourcing:
  - The shifter `In`/`Cnt`/`Op` are muxed from the granted port.
  - With no grant, port A fields drive the shifter; the output is ignored.
- On a grant, `Out` is captured into the granted port's response buffer at the next rising edge, and `x_rsp_valid` is set.
- Response buffer:
  - Holds `x_rsp_valid` and `x_rsp_data` stable until `x_rsp_ready` is 1.
  - Clears on consume unless refilled by a grant in the same cycle.
- Requester side:
  - A requester must hold its fields stable while valid and not ready.
  - The block does not check this.
- Arithmetic is fully defined by `shifter`:
  - `Cnt` = 0 passes `In` unchanged for all ops.
  - srl fills with zeros; rotates wrap modulo 16.

## Timing
- Reset (async assert, sync-clean deassert on the `clk` edge):
  - `a_rsp_valid` = `b_rsp_valid` = 0.
  - `a_rsp_data` = `b_rsp_data` = 16'h0000.
  - `last_grant` = 1, so port A wins the first contention.
  - `x_req_ready` is 0 while `rst_n` = 0.
- Reset mid-operation: pending responses are discarded. A request handshaking in the same cycle as reset assertion is lost.
- Latency is 1 cycle: a request accepted at edge N has its result valid after edge N. The earliest consume is at edge N+1.
- Throughput per port: 1 request per cycle when the port drains every cycle (`x_rsp_ready` held at 1).
- Aggregate throughput: 1 shift per cycle.
- Under continuous contention, grants alternate A, B, A, B.
- Port back-pressure: with `x_rsp_valid` = 1 and `x_rsp_ready` = 0, that port gets no grant. The other port may be granted every cycle.

## Configuration
- `SHIFT_ARB_FIXED_PRI_EN`
- Defined: port A always wins when both ports are eligible. `last_grant` still tracks grants but does not affect selection.
- Undefined (default): round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single A request: `a_in`=16'h8001, `a_cnt`=1, `a_op`=00 (rol).
  - `a_req_ready`=1 in the same cycle.
  - Next cycle `a_rsp_valid`=1, `a_rsp_data`=16'h0003.
  - `b_rsp_valid` stays 0.
- Contention from reset:
  - A requests (16'hF000, cnt 4, srl); B requests (16'h0001, cnt 15, sll), both held.
  - With responses always ready: A granted first, giving 16'h0F00; B second, giving 16'h8000.
  - Pattern alternates, `last_grant` toggles 0,1,0.
  - With `SHIFT_ARB_FIXED_PRI_EN`: A granted every cycle, B starved.
- Back-pressure: `a_rsp_ready`=0 with A result held.
  - A's next request sees `a_req_ready`=0 and `a_rsp_data` remains stable.
  - B requests are granted each cycle.
  - Raise `a_rsp_ready`: A gets the grant in that same cycle (drain-and-refill), and `a_rsp_valid` stays 1 with new data.
- Boundary ops: B sends 16'h1234 with cnt 0 for each op.
  - Every result is 16'h1234.
  - B sends 16'h1234, cnt 8, ror: result 16'h3412.
- Async reset mid-stream: assert `rst_n`=0 between edges while both responses are valid.
  - `a_rsp_valid`/`b_rsp_valid` drop to 0 immediately.
  - Both `*_rsp_data` = 0.
  - After release, A wins the first contention.
